// File: rtl/bsg_manycore_remote_req_ctrl.sv
// Remote request sequencer between the core packet encoder and the network link.
// Buffers one packet, throttles stores by credits, tracks four lock slots.
module bsg_manycore_remote_req_ctrl #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 16,
  parameter int max_out_credits_p = 16,
  localparam int packet_width_lp = 2 + data_width_p / 8 + data_width_p
    + addr_width_p + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic v_i,
  input  logic req_lock_i,
  input  logic [1:0] lock_num_i,
  input  logic rel_lock_i,
  input  logic ret_store_cntr_i,
  input  logic req_lock_stat_i,
  input  logic [packet_width_lp-1:0] pkt_i,
  output logic ready_o,
  output logic link_v_o,
  output logic [packet_width_lp-1:0] link_data_o,
  input  logic link_ready_i,
  input  logic credit_return_i,
  input  logic lock_resp_v_i,
  input  logic lock_resp_grant_i,
  output logic ret_v_o,
  output logic [data_width_p-1:0] ret_data_o,
  output logic [credit_width_lp-1:0] credits_o,
  output logic [3:0] lock_held_o,
  output logic err_o
);

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_wait_lock = 1'b1;
  localparam int cw1 = credit_width_lp + 1;

  logic [0:0] state_r;
  logic buf_v_r;
  logic buf_lock_r;
  logic [1:0] buf_slot_r;
  logic [1:0] lock_slot_r;
  logic [packet_width_lp-1:0] buf_data_r;
  logic [credit_width_lp-1:0] credits_r;
  logic [3:0] lock_held_r;
  logic err_r;
  logic ret_v_r;
  logic [data_width_p-1:0] ret_data_r;
  logic [data_width_p-1:0] ret_next;

  logic drain, local_op, multi_op, pend, credit_ok, base;
  logic accept_req, accept_local;
  logic hs_lock, hs_store, resp_ok;
  logic do_rsc, do_rls, do_rel, err_set;

  assign drain = buf_v_r & link_ready_i;
  assign local_op = ret_store_cntr_i | req_lock_stat_i | rel_lock_i;
  assign multi_op = (ret_store_cntr_i & req_lock_stat_i)
                  | (ret_store_cntr_i & rel_lock_i)
                  | (req_lock_stat_i & rel_lock_i);
  assign pend = buf_v_r & ~buf_lock_r;
  // a buffered store already owns a credit slot before it reaches the link
  assign credit_ok = ({1'b0, credits_r} + cw1'(pend))
                   < cw1'(max_out_credits_p);
  assign base = (state_r == st_idle) & (~buf_v_r | drain) & ~buf_lock_r;
  assign ready_o = base & (local_op | req_lock_i | credit_ok);

  assign accept_req = v_i & ready_o & ~local_op;
  assign accept_local = local_op & ready_o;
  assign hs_lock = drain & buf_lock_r;
  assign hs_store = drain & ~buf_lock_r;
  assign resp_ok = (state_r == st_wait_lock) & lock_resp_v_i;

  assign do_rsc = accept_local & ret_store_cntr_i;
  assign do_rls = accept_local & ~ret_store_cntr_i & req_lock_stat_i;
  assign do_rel = accept_local & ~ret_store_cntr_i & ~req_lock_stat_i
                & rel_lock_i;

  assign err_set = (credit_return_i & ~hs_store & (credits_r == '0))
                 | (do_rel & ~lock_held_r[lock_num_i])
                 | (accept_local & multi_op)
                 | (lock_resp_v_i & (state_r != st_wait_lock));

  always_comb begin
    ret_next = '0;
    unique case (1'b1)
      resp_ok: ret_next = data_width_p'(lock_resp_grant_i);
      do_rsc:  ret_next = data_width_p'(credits_r);
      do_rls:  ret_next = data_width_p'(lock_held_r);
      default: ret_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= st_idle;
      buf_v_r <= 1'b0;
      buf_lock_r <= 1'b0;
      buf_slot_r <= '0;
      buf_data_r <= '0;
      lock_slot_r <= '0;
      credits_r <= '0;
      lock_held_r <= '0;
      err_r <= 1'b0;
      ret_v_r <= 1'b0;
      ret_data_r <= '0;
    end else begin
      if (accept_req) begin
        buf_v_r <= 1'b1;
        buf_data_r <= pkt_i;
        buf_lock_r <= req_lock_i;
        buf_slot_r <= lock_num_i;
      end else if (drain) begin
        buf_v_r <= 1'b0;
        buf_data_r <= '0;
        buf_lock_r <= 1'b0;
      end
      if (hs_lock) begin
        state_r <= st_wait_lock;
        lock_slot_r <= buf_slot_r;
      end else if (resp_ok) begin
        state_r <= st_idle;
      end
      if (hs_store & ~credit_return_i) begin
        credits_r <= credits_r + 1'b1;
      end else if (~hs_store & credit_return_i & (credits_r != '0)) begin
        credits_r <= credits_r - 1'b1;
      end
      if (resp_ok & lock_resp_grant_i) begin
        lock_held_r[lock_slot_r] <= 1'b1;
      end else if (do_rel) begin
        lock_held_r[lock_num_i] <= 1'b0;
      end
      if (err_set) err_r <= 1'b1;
      ret_v_r <= resp_ok | do_rsc | do_rls;
      ret_data_r <= ret_next;
    end
  end

  assign link_v_o = buf_v_r;
  assign link_data_o = buf_data_r;
  assign ret_v_o = ret_v_r;
  assign ret_data_o = ret_data_r;
  assign credits_o = credits_r;
  assign lock_held_o = lock_held_r;
  assign err_o = err_r;

endmodule

// File: tb/tb_bsg_manycore_remote_req_ctrl.sv
// Bench for bsg_manycore_remote_req_ctrl: packet and load-return scoreboards
// plus inline register checks, one task per scenario.
module tb_bsg_manycore_remote_req_ctrl;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MAXC = 4;
  localparam int PW = 2 + DW / 8 + DW + AW + 2 * (XW + YW);
  localparam int CW = $clog2(MAXC + 1);

  logic clk, rst_n;
  logic v, req_lock, rel, rsc, rls;
  logic [1:0] lock_num;
  logic [PW-1:0] pkt;
  logic link_ready, credit_ret, resp_v, grant;
  logic ready_o, link_v_o, ret_v_o, err_o;
  logic [PW-1:0] link_data_o;
  logic [DW-1:0] ret_data_o;
  logic [CW-1:0] credits_o;
  logic [3:0] lock_held_o;

  int total = 0;
  int bad = 0;
  logic [PW-1:0] pkt_q[$];
  logic [DW-1:0] ret_q[$];

  bsg_manycore_remote_req_ctrl #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
    .addr_width_p(AW), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .req_lock_i(req_lock),
    .lock_num_i(lock_num), .rel_lock_i(rel), .ret_store_cntr_i(rsc),
    .req_lock_stat_i(rls), .pkt_i(pkt), .ready_o(ready_o),
    .link_v_o(link_v_o), .link_data_o(link_data_o),
    .link_ready_i(link_ready), .credit_return_i(credit_ret),
    .lock_resp_v_i(resp_v), .lock_resp_grant_i(grant),
    .ret_v_o(ret_v_o), .ret_data_o(ret_data_o), .credits_o(credits_o),
    .lock_held_o(lock_held_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin : mon
    logic [PW-1:0] ep;
    logic [DW-1:0] er;
    if (rst_n) begin
      if (link_v_o && link_ready) begin
        total++;
        if (pkt_q.size() == 0) begin
          bad++;
          $display("FAIL link_pkt: unexpected packet %h", link_data_o);
        end else begin
          ep = pkt_q.pop_front();
          if (link_data_o !== ep) begin
            bad++;
            $display("FAIL link_pkt: got %h required %h", link_data_o, ep);
          end
        end
      end
      total++;
      if (ret_v_o) begin
        if (ret_q.size() == 0) begin
          bad++;
          $display("FAIL ret: unexpected return %h", ret_data_o);
        end else begin
          er = ret_q.pop_front();
          if (ret_data_o !== er) begin
            bad++;
            $display("FAIL ret: got %h required %h", ret_data_o, er);
          end
        end
      end else if (ret_data_o !== '0) begin
        bad++;
        $display("FAIL ret_idle: got %h required 0", ret_data_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return PW'(r);
  endfunction

  task automatic send(input logic [PW-1:0] p, input logic lk,
                      input logic [1:0] n, output int waits);
    v = 1'b1;
    pkt = p;
    req_lock = lk;
    lock_num = n;
    waits = 0;
    #1;
    while (!ready_o && waits < 20) begin
      @(posedge clk);
      #2;
      waits++;
    end
    total++;
    if (!ready_o) begin
      bad++;
      $display("FAIL send_timeout: ready_o=%b required 1", ready_o);
    end else begin
      pkt_q.push_back(p);
    end
    tick();
    v = 1'b0;
    req_lock = 1'b0;
  endtask

  task automatic do_local(input logic sc, input logic st, input logic rl,
                          input logic [1:0] n, input logic [DW-1:0] er);
    rsc = sc;
    rls = st;
    rel = rl;
    lock_num = n;
    #1;
    total++;
    if (!ready_o) begin
      bad++;
      $display("FAIL local_ready: ready_o=%b required 1", ready_o);
    end else if (sc | st) begin
      ret_q.push_back(er);
    end
    tick();
    rsc = 1'b0;
    rls = 1'b0;
    rel = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {v, req_lock, rel, rsc, rls, credit_ret, resp_v, grant} = '0;
    lock_num = '0;
    pkt = '0;
    link_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({ready_o, link_v_o, ret_v_o, err_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: rdy,lv,rv,err=%b required 1000",
               {ready_o, link_v_o, ret_v_o, err_o});
    end
    total++;
    if (credits_o !== '0 || lock_held_o !== 4'b0) begin
      bad++;
      $display("FAIL reset_regs: credits=%0d held=%b required 0 0000",
               credits_o, lock_held_o);
    end
    total++;
    if (link_data_o !== '0 || ret_data_o !== '0) begin
      bad++;
      $display("FAIL reset_data: link=%h ret=%h required 0 0",
               link_data_o, ret_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_stream();
    int w;
    logic [PW-1:0] p5;
    for (int i = 0; i < 4; i++) begin
      send(rnd_pkt(), 1'b0, 2'd0, w);
      total++;
      if (w !== 0) begin
        bad++;
        $display("FAIL stream_wait: store %0d waited %0d required 0", i, w);
      end
    end
    p5 = rnd_pkt();
    v = 1'b1;
    pkt = p5;
    #1;
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_full: ready_o=%b required 0", ready_o);
    end
    tick();
    total++;
    if (credits_o !== CW'(4) || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_credits: credits=%0d ready=%b required 4 0",
               credits_o, ready_o);
    end
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL stream_resume: ready_o=%b required 1", ready_o);
    end else begin
      pkt_q.push_back(p5);
    end
    tick();
    v = 1'b0;
    tick();
    tick();
    total++;
    if (credits_o !== CW'(4)) begin
      bad++;
      $display("FAIL stream_final: credits=%0d required 4", credits_o);
    end
  endtask

  task automatic test_link_stall();
    int w;
    logic [PW-1:0] pa;
    credit_ret = 1'b1;
    tick();
    tick();
    credit_ret = 1'b0;
    link_ready = 1'b0;
    pa = rnd_pkt();
    send(pa, 1'b0, 2'd0, w);
    v = 1'b1;
    pkt = rnd_pkt();
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (link_v_o !== 1'b1 || link_data_o !== pa || ready_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: lv=%b data=%h rdy=%b required 1 %h 0",
                 link_v_o, link_data_o, ready_o, pa);
      end
      tick();
    end
    link_ready = 1'b1;
    send(pkt, 1'b0, 2'd0, w);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL stall_release: waited %0d required 0", w);
    end
    tick();
    tick();
  endtask

  task automatic test_store_cntr();
    int w;
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    do_local(1'b1, 1'b0, 1'b0, 2'd0, 32'd3);
    send(rnd_pkt(), 1'b0, 2'd0, w);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    total++;
    if (credits_o !== CW'(3)) begin
      bad++;
      $display("FAIL credit_simul: credits=%0d required 3", credits_o);
    end
    do_local(1'b1, 1'b0, 1'b0, 2'd0, 32'd3);
  endtask

  task automatic test_lock();
    int w;
    send(rnd_pkt(), 1'b1, 2'd2, w);
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL lock_stall: ready_o=%b required 0", ready_o);
    end
    repeat (4) tick();
    resp_v = 1'b1;
    grant = 1'b1;
    ret_q.push_back(32'd1);
    tick();
    resp_v = 1'b0;
    grant = 1'b0;
    total++;
    if (lock_held_o !== 4'b0100 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL lock_grant: held=%b rdy=%b required 0100 1",
               lock_held_o, ready_o);
    end
    send(rnd_pkt(), 1'b1, 2'd0, w);
    tick();
    tick();
    resp_v = 1'b1;
    ret_q.push_back(32'd0);
    tick();
    resp_v = 1'b0;
    total++;
    if (lock_held_o !== 4'b0100) begin
      bad++;
      $display("FAIL lock_deny: held=%b required 0100", lock_held_o);
    end
    do_local(1'b0, 1'b1, 1'b0, 2'd0, 32'h4);
  endtask

  task automatic test_release_err();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clean: err=%b required 0", err_o);
    end
    do_local(1'b0, 1'b0, 1'b1, 2'd2, '0);
    total++;
    if (lock_held_o !== 4'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL release: held=%b err=%b required 0000 0",
               lock_held_o, err_o);
    end
    do_local(1'b0, 1'b0, 1'b1, 2'd1, '0);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL rel_unheld: err=%b required 1", err_o);
    end
    repeat (3) tick();
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%b required 1", err_o);
    end
  endtask

  task automatic test_reset_mid_lock();
    int w;
    send(rnd_pkt(), 1'b1, 2'd3, w);
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready_o, link_v_o, ret_v_o, err_o} !== 4'b1000 ||
        credits_o !== '0 || lock_held_o !== 4'b0) begin
      bad++;
      $display("FAIL mid_reset: flags=%b credits=%0d held=%b required 1000 0 0000",
               {ready_o, link_v_o, ret_v_o, err_o}, credits_o, lock_held_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    resp_v = 1'b1;
    grant = 1'b1;
    tick();
    resp_v = 1'b0;
    grant = 1'b0;
    total++;
    if (err_o !== 1'b1 || lock_held_o !== 4'b0) begin
      bad++;
      $display("FAIL stray_resp: err=%b held=%b required 1 0000",
               err_o, lock_held_o);
    end
  endtask

  task automatic test_credit_err();
    pulse_reset();
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    total++;
    if (err_o !== 1'b1 || credits_o !== '0) begin
      bad++;
      $display("FAIL credit_underflow: err=%b credits=%0d required 1 0",
               err_o, credits_o);
    end
  endtask

  task automatic test_combined();
    pulse_reset();
    v = 1'b1;
    pkt = rnd_pkt();
    rsc = 1'b1;
    rls = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL combo_ready: ready_o=%b required 1", ready_o);
    end else begin
      ret_q.push_back(32'd0);
    end
    tick();
    {v, rsc, rls} = '0;
    total++;
    if (err_o !== 1'b1 || link_v_o !== 1'b0) begin
      bad++;
      $display("FAIL combo: err=%b lv=%b required 1 0", err_o, link_v_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_stream();
    test_link_stall();
    test_store_cntr();
    test_lock();
    test_release_err();
    test_reset_mid_lock();
    test_credit_err();
    test_combined();
    repeat (3) tick();
    total++;
    if (pkt_q.size() !== 0 || ret_q.size() !== 0) begin
      bad++;
      $display("FAIL drain: pkts=%0d rets=%0d required 0 0",
               pkt_q.size(), ret_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_remote_req_ctrl.md
Name: bsg_manycore_remote_req_ctrl

Overview:
Sequencer between the core-side packet encoder and the manycore network link.
- Accepts encoded remote requests (stores, lock acquire) and buffers one packet.
- Issues packets to the link under valid/ready and throttles stores with an outstanding-store credit counter.
- Tracks four lock slots and answers local queries (store counter read, lock status) as load returns, stalling the core while a lock acquire is in flight.

Parameters:
x_cord_width_p, "inv", X coordinate width
y_cord_width_p, "inv", Y coordinate width
data_width_p, "inv", data word width; also the width of ret_data_o
addr_width_p, "inv", packet address width
max_out_credits_p, 16, maximum outstanding stores; must be ≥1 and < 2^data_width_p
packet_width_lp, derived, bsg_manycore_packet_width(addr_width_p,data_width_p,x_cord_width_p,y_cord_width_p)
credit_width_lp, derived, $clog2(max_out_credits_p+1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
v_i  in  1  encoded remote request valid (store or lock acquire)
req_lock_i  in  1  request is a lock acquire
lock_num_i  in  2  lock slot index for acquire, release or status
rel_lock_i  in  1  local lock release request
ret_store_cntr_i  in  1  read outstanding-store count
req_lock_stat_i  in  1  read lock-held vector
pkt_i  in  packet_width_lp  encoded packet
ready_o  out  1  request accepted this cycle; otherwise the core stalls
link_v_o  out  1  packet valid to network
link_data_o  out  packet_width_lp  packet to network
link_ready_i  in  1  network accepts the packet
credit_return_i  in  1  one store acknowledged
lock_resp_v_i  in  1  lock response valid
lock_resp_grant_i  in  1  1 = granted, 0 = denied
ret_v_o  out  1  load-return valid
ret_data_o  out  data_width_p  load-return data
credits_o  out  credit_width_lp  outstanding-store count
lock_held_o  out  4  per-slot lock-held flags
err_o  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous assert, synchronous deassert expected from the system):
  - state=IDLE; buffer empty; credits=0; lock_held=0; err=0.
  - ready_o=1, link_v_o=0, link_data_o=0, ret_v_o=0, ret_data_o=0.
  - Reset mid-WAIT_LOCK or with a packet buffered drops that packet; no response is generated.
- States:
  - IDLE: accepts requests.
  - WAIT_LOCK: entered on the link handshake of a lock packet; ready_o=0.
  - WAIT_LOCK→IDLE on lock_resp_v_i. If grant=1, lock_held[slot] is set (slot latched at accept). ret_v_o=1 with ret_data_o={0,grant} on the next cycle.
- ready_o is 1 only when all of the following hold:
  - state==IDLE;
  - the buffer is empty or draining this cycle (link_v_o & link_ready_i);
  - no lock packet is buffered;
  - for stores only, credits + pending_buffered_store < max_out_credits_p.
- Request accept (v_i & ready_o):
  - The packet is registered; link_v_o=1 on the next cycle.
  - link_data_o is held stable until link_ready_i.
  - Throughput is one packet per cycle while the link is ready.
- Credits:
  - +1 on the link handshake of a store packet; -1 on credit_return_i.
  - Both in the same cycle leaves the count unchanged.
  - credit_return_i at count 0 sets err_o; the count stays 0.
- Local ops: ret_store_cntr_i, req_lock_stat_i and rel_lock_i are accepted only when ready_o=1, with the same stall rule.
  - ret_store_cntr_i: next cycle ret_v_o=1, ret_data_o=zero-extended credits.
  - req_lock_stat_i: next cycle ret_v_o=1, ret_data_o=zero-extended lock_held.
  - rel_lock_i: clears lock_held[lock_num_i] next cycle; no return, no packet.
  - Releasing a slot that is not held sets err_o.
- Combined requests:
  - v_i with a local op in the same cycle: the local op takes priority, v_i is not accepted, ready_o=0 for v_i.
  - More than one local op asserted in the same cycle sets err_o; only the highest-priority op (store-counter read > status > release) executes.
- lock_resp_v_i outside WAIT_LOCK sets err_o and is otherwise ignored.
- ret_v_o is a single-cycle pulse; ret_data_o is 0 when ret_v_o=0.

Test Plan:
- Store stream, link always ready, max=4, no returns → 4 packets, ready_o=0 on the 5th, credits_o=4; one credit_return_i → ready_o=1, 5th packet sent.
- link_ready_i low for 3 cycles with a packet buffered → link_v_o=1 and link_data_o held constant; ready_o=0 until the handshake.
- Lock acquire on slot 2 → packet sent, ready_o=0; grant response after 5 cycles → ret_v_o=1, ret_data_o=1, lock_held_o=4'b0100; deny case → ret_data_o=0, lock_held_o unchanged.
- credits=3 and ret_store_cntr_i → ret_data_o=3; simultaneous credit_return_i and store handshake → credits_o stays 3.
- Release of an unheld slot 1, or credit_return_i at 0 → err_o=1 and stays 1 until reset.
- reset_n_i asserted during WAIT_LOCK → all outputs at reset values immediately; after deassert, a later lock_resp_v_i sets err_o.
